// File: rtl/logic_analyzer.sv
// rtl/logic_analyzer.sv - 3-channel edge-triggered logic analyzer with UART dump
//
// Arms with a reference taken from the synchronized probes. Any change from that
// reference triggers a capture of DEPTH samples spaced SAMPLE_DIV clocks apart.
// Each sample is then sent as one 8N1 UART byte {5'b0, sample}, LSB first.
// Define LA_HEADER_EN to prefix each dump with a 0xA5 header frame.
//
// Ports:
//   inclk0_10MHz      system clock, all logic on the rising edge
//   rst               synchronous active-high reset
//   dataIn[2:0]       asynchronous probe inputs
//   TxD               UART serial output, idle high
//   pll_output_debug  clock/2 square wave
//   clk_div16_debug   clock/16 square wave
//   dataOut_debug     byte currently held in the UART shifter
//   state_debug       FSM state code, zero-extended to 5 bits
module logic_analyzer #(
    parameter int DEPTH        = 16,
    parameter int SAMPLE_DIV   = 16,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       inclk0_10MHz,
    input  logic       rst,
    input  logic [2:0] dataIn,
    output logic       TxD,
    output logic       pll_output_debug,
    output logic       clk_div16_debug,
    output logic [7:0] dataOut_debug,
    output logic [4:0] state_debug
);

`ifdef LA_HEADER_EN
    localparam int NFRAMES = DEPTH + 1;
    localparam int HDR     = 1;
`else
    localparam int NFRAMES = DEPTH;
    localparam int HDR     = 0;
`endif

    localparam int IW = $clog2(DEPTH);
    localparam int DW = $clog2(SAMPLE_DIV + 1);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);
    localparam int FW = $clog2(NFRAMES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        CAPTURE  = 3'd2,
        TX_LOAD  = 3'd3,
        TX_START = 3'd4,
        TX_DATA  = 3'd5,
        TX_STOP  = 3'd6,
        DONE     = 3'd7
    } state_t;

    state_t state, state_nx;

    logic [2:0]    sync1, sync2, ref_val;
    logic [2:0]    sample_buf [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic [2:0]    bit_idx;
    logic [FW-1:0] tx_idx;
    logic [7:0]    tx_byte;
    logic [7:0]    load_byte;
    logic [2:0]    dbg_cnt;

    logic trig, cap_tick, last_sample, bit_end, last_frame;

    assign trig        = (sync2 != ref_val);
    assign cap_tick    = (div_cnt == DW'(SAMPLE_DIV - 1));
    assign last_sample = (wr_idx == IW'(DEPTH - 1));
    assign bit_end     = (bit_cnt == BW'(CLKS_PER_BIT - 1));
    assign last_frame  = (tx_idx == FW'(NFRAMES - 1));

    // Frame number maps to sample number by skipping the optional header slot.
    assign rd_idx = IW'(tx_idx - FW'(HDR));

`ifdef LA_HEADER_EN
    assign load_byte = (tx_idx == '0) ? 8'hA5 : {5'b00000, sample_buf[rd_idx]};
`else
    assign load_byte = {5'b00000, sample_buf[rd_idx]};
`endif

    assign dataOut_debug = tx_byte;
    assign state_debug   = {2'b00, state};

    always_ff @(posedge inclk0_10MHz) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = ARMED;
            ARMED:    if (trig) state_nx = CAPTURE;
            CAPTURE:  if (cap_tick && last_sample) state_nx = TX_LOAD;
            TX_LOAD:  state_nx = TX_START;
            TX_START: if (bit_end) state_nx = TX_DATA;
            TX_DATA:  if (bit_end && bit_idx == 3'd7) state_nx = TX_STOP;
            TX_STOP:  if (bit_end) state_nx = last_frame ? DONE : TX_LOAD;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        TxD = 1'b1;
        if (state == TX_START)     TxD = 1'b0;
        else if (state == TX_DATA) TxD = tx_byte[bit_idx];
    end

    // Sample storage is not reset; contents are only meaningful after a trigger.
    always_ff @(posedge inclk0_10MHz) begin
        if (!rst) begin
            if (state == ARMED && trig)          sample_buf[0]      <= sync2;
            else if (state == CAPTURE && cap_tick) sample_buf[wr_idx] <= sync2;
        end
    end

    always_ff @(posedge inclk0_10MHz) begin
        if (rst) begin
            sync1            <= '0;
            sync2            <= '0;
            ref_val          <= '0;
            wr_idx           <= '0;
            div_cnt          <= '0;
            bit_cnt          <= '0;
            bit_idx          <= '0;
            tx_idx           <= '0;
            tx_byte          <= '0;
            dbg_cnt          <= '0;
            pll_output_debug <= 1'b0;
            clk_div16_debug  <= 1'b0;
        end else begin
            sync1 <= dataIn;
            sync2 <= sync1;

            pll_output_debug <= ~pll_output_debug;
            dbg_cnt          <= dbg_cnt + 3'd1;
            if (dbg_cnt == 3'd7) clk_div16_debug <= ~clk_div16_debug;

            case (state)
                IDLE: begin
                    ref_val <= sync2;
                    tx_idx  <= '0;
                end
                ARMED: begin
                    if (trig) begin
                        wr_idx  <= IW'(1);
                        div_cnt <= '0;
                    end
                end
                CAPTURE: begin
                    if (cap_tick) begin
                        div_cnt <= '0;
                        wr_idx  <= wr_idx + IW'(1);
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                TX_LOAD: begin
                    tx_byte <= load_byte;
                    bit_cnt <= '0;
                end
                TX_START: begin
                    bit_idx <= '0;
                    bit_cnt <= bit_end ? '0 : bit_cnt + BW'(1);
                end
                TX_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (!last_frame) tx_idx <= tx_idx + FW'(1);
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_analyzer.sv
// tb/tb_logic_analyzer.sv - randomized self-checking bench for logic_analyzer
module tb_logic_analyzer;

    localparam int DEPTH = 16;
    localparam int SD    = 16;
    localparam int CPB   = 16;
    localparam int FRAME = CPB * 10 + 1;
    localparam int NH    = 32768;
`ifdef LA_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int NFR = DEPTH + HDR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dataIn = 3'd0;
    logic       TxD, pll_output_debug, clk_div16_debug;
    logic [7:0] dataOut_debug;
    logic [4:0] state_debug;

    logic_analyzer #(.DEPTH(DEPTH), .SAMPLE_DIV(SD), .CLKS_PER_BIT(CPB)) dut (
        .inclk0_10MHz    (clk),
        .rst             (rst),
        .dataIn          (dataIn),
        .TxD             (TxD),
        .pll_output_debug(pll_output_debug),
        .clk_div16_debug (clk_div16_debug),
        .dataOut_debug   (dataOut_debug),
        .state_debug     (state_debug)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic       tog_stop = 1'b0;

    logic [2:0] din_hist  [NH];
    logic       rst_hist  [NH];
    logic       txd_hist  [NH];
    logic [4:0] st_hist   [NH];
    logic [7:0] dout_hist [NH];
    logic       pll_hist  [NH];
    logic       d16_hist  [NH];
    int         rx [NFR];

    // Edge n: inputs as the DUT sees them at that rising edge.
    always @(posedge clk) begin
        if (cyc + 1 < NH) begin
            din_hist[cyc+1] <= dataIn;
            rst_hist[cyc+1] <= rst;
        end
        cyc <= cyc + 1;
    end

    // Outputs as they settle after edge n.
    always @(negedge clk) begin
        if (cyc < NH) begin
            txd_hist[cyc]  <= TxD;
            st_hist[cyc]   <= state_debug;
            dout_hist[cyc] <= dataOut_debug;
            pll_hist[cyc]  <= pll_output_debug;
            d16_hist[cyc]  <= clk_div16_debug;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Probe value visible to the FSM at edge n: two flops of delay, zero if either
    // flop was held in reset.
    function automatic logic [2:0] sync_at(input int n);
        if (n < 3 || n >= NH) return 3'd0;
        if (rst_hist[n-1] === 1'b0 && rst_hist[n-2] === 1'b0) return din_hist[n-2];
        return 3'd0;
    endfunction

    task automatic wait_state(input int s, input string tag);
        int k = 0;
        while (int'(state_debug) != s && k < 8000) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, int'(state_debug), s);
    endtask

    task automatic toggler();
        while (!tog_stop) begin
            #($urandom_range(3, 40));
            if (($time % 10) == 5) #2;
            dataIn = 3'($urandom);
        end
    endtask

    // Rebuilds the expected dump for a session whose IDLE edge is idle_edge and
    // compares it against the recorded TxD line, dataOut_debug and state codes.
    task automatic analyze(input int idle_edge, output int next_idle);
        logic [2:0] refv;
        logic [7:0] exp_b [$];
        logic [7:0] got;
        int trig, base, e, idx, errs, last;
        refv = sync_at(idle_edge);
        trig = -1;
        for (int n = idle_edge + 1; n <= cyc - 2 && trig < 0; n++)
            if (sync_at(n) != refv) trig = n;
        check_eq("trigger_found", int'(trig >= 0), 1);
        next_idle = cyc;
        if (trig < 0) return;
        base = trig + (DEPTH - 1) * SD + 1;
        last = base + (NFR - 1) * FRAME;
        if (last + 163 >= NH || last + 163 > cyc) begin
            check_eq("history_range", 0, 1);
            return;
        end
`ifdef LA_HEADER_EN
        exp_b.push_back(8'hA5);
`endif
        for (int k = 0; k < DEPTH; k++) exp_b.push_back({5'b00000, sync_at(trig + k * SD)});
        for (int j = 0; j < NFR; j++) begin
            e = base + j * FRAME;
            errs = 0;
            for (int m = e - 1; m <= e + FRAME - 1; m++) begin
                logic ev;
                idx = m - e;
                if (idx < 0)            ev = 1'b1;
                else if (idx < CPB)     ev = 1'b0;
                else if (idx < 9 * CPB) ev = exp_b[j][(idx - CPB) / CPB];
                else                    ev = 1'b1;
                if (txd_hist[m] !== ev) errs++;
            end
            for (int b = 0; b < 8; b++) got[b] = txd_hist[e + CPB + b * CPB + CPB / 2];
            rx[j] = int'(got);
            check_eq($sformatf("frame%0d_byte", j), int'(got), int'(exp_b[j]));
            check_eq($sformatf("frame%0d_wave_errs", j), errs, 0);
            check_eq($sformatf("frame%0d_dout", j), int'(dout_hist[e + 5 * CPB]), int'(exp_b[j]));
        end
        check_eq("state_done", int'(st_hist[last + 160]), 7);
        check_eq("state_idle", int'(st_hist[last + 161]), 0);
        check_eq("state_rearm", int'(st_hist[last + 162]), 1);
        next_idle = last + 162;
    endtask

    initial begin
        int r, nxt, x, lr, bad, c;

        // Reset for 5 clocks with probes low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("rst_txd", int'(TxD), 1);
            check_eq("rst_state", int'(state_debug), 0);
        end
        check_eq("rst_dout", int'(dataOut_debug), 0);
        rst = 1'b0;
        r = cyc + 1;
        @(negedge clk);
        check_eq("armed_after_reset", int'(state_debug), 1);

        // Directed staircase: trigger on 001, rest of the samples settle at 110.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        for (int v = 1; v <= 6; v++) begin
            dataIn = 3'(v);
            #15;
        end
        wait_state(7, "directed_done");
        repeat (4) @(negedge clk);
        analyze(r, nxt);
        check_eq("directed_first", rx[HDR], 1);
        check_eq("directed_second", rx[HDR + 1], 6);
        check_eq("directed_last", rx[NFR - 1], 6);
`ifdef LA_HEADER_EN
        check_eq("directed_header", rx[0], 8'hA5);
`endif

        // Random probe activity, continuing through capture and transmission.
        for (int s = 0; s < 3; s++) begin
            tog_stop = 1'b0;
            fork
                toggler();
                begin
                    wait_state(7, "random_done");
                    tog_stop = 1'b1;
                end
            join
            repeat (4) @(negedge clk);
            analyze(nxt, nxt);
        end

        // One-clock reset pulse in the middle of a data bit, then a fresh session.
        tog_stop = 1'b0;
        fork
            toggler();
            begin
                wait_state(5, "reach_tx_data");
                repeat (20) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                x = cyc;
                check_eq("abort_state", int'(state_debug), 0);
                check_eq("abort_txd", int'(TxD), 1);
                rst = 1'b0;
                wait_state(7, "after_abort_done");
                tog_stop = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        analyze(x + 1, nxt);

        // Debug square waves restart from zero at every reset edge.
        lr = -1;
        bad = 0;
        for (int n = 1; n < cyc - 1 && n < NH; n++) begin
            if (rst_hist[n] === 1'b1) begin
                lr = n;
                if (pll_hist[n] !== 1'b0 || d16_hist[n] !== 1'b0) bad++;
            end else if (lr >= 0) begin
                c = n - lr;
                if (pll_hist[n] !== 1'(c % 2)) bad++;
                if (d16_hist[n] !== 1'((c / 8) % 2)) bad++;
            end
        end
        check_eq("debug_clocks", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_analyzer.md
LOGIC_ANALYZER -- requirements
Module: logic_analyzer

Interface
REQ-001 Parameter DEPTH, default 16: number of samples captured per trigger (power of two, 2..64).
REQ-002 Parameter SAMPLE_DIV, default 16: clocks between consecutive samples (>=1).
REQ-003 Parameter CLKS_PER_BIT, default 16: clocks per UART bit.
REQ-004 inclk0_10MHz  input  1  sole system clock, 10 MHz nominal, all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 dataIn  input  3  asynchronous probe inputs.
REQ-007 TxD  output  1  UART serial out, 8N1, LSB first, idle high.
REQ-008 pll_output_debug  output  1  clock/2 debug square wave, toggles every clock.
REQ-009 clk_div16_debug  output  1  clock/16 debug square wave, toggles every 8 clocks.
REQ-010 dataOut_debug  output  8  byte currently loaded in the UART shifter.
REQ-011 state_debug  output  5  current FSM state code, zero-extended.

Function
REQ-012 dataIn passes through a 2-flop synchronizer; all comparisons and samples use the synchronized value (2-cycle latency).
REQ-013 FSM codes: IDLE=0, ARMED=1, CAPTURE=2, TX_LOAD=3, TX_START=4, TX_DATA=5, TX_STOP=6, DONE=7.
REQ-014 IDLE: store synchronized dataIn as reference, go ARMED next cycle.
REQ-015 ARMED: when synchronized dataIn != reference, write it as sample 0 in that cycle and go CAPTURE; otherwise stay.
REQ-016 CAPTURE: sample k (k=1..DEPTH-1) written exactly k*SAMPLE_DIV clocks after the trigger cycle; after sample DEPTH-1 go TX_LOAD.
REQ-017 Sample buffer: DEPTH x 3 bits, write index wraps to 0 only at the next trigger.
REQ-018 TX_LOAD: load byte {5'b00000, sample[i]} into shifter and dataOut_debug, i starting at 0; go TX_START.
REQ-019 TX_START drives TxD=0 for CLKS_PER_BIT clocks; TX_DATA drives 8 data bits LSB first, CLKS_PER_BIT clocks each; TX_STOP drives TxD=1 for CLKS_PER_BIT clocks.
REQ-020 After TX_STOP: if i < DEPTH-1, increment i and go TX_LOAD; else go DONE; bytes back-to-back with one TX_LOAD clock (TxD=1) between them.
REQ-021 DONE lasts one clock, then IDLE (re-arms with a fresh reference).
REQ-022 Input changes during CAPTURE (other than sample points), TX_* or DONE are ignored; no retrigger until ARMED.
REQ-023 Bit timer is a dedicated counter restarted at each bit; independent of clk_div16_debug phase.
REQ-024 TxD is 1 in IDLE, ARMED, CAPTURE, TX_LOAD, DONE.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, TxD=1, dataOut_debug=0, pll_output_debug=0, clk_div16_debug=0, all counters and index 0, synchronizer 0.
REQ-026 rst asserted mid-capture or mid-transmission aborts immediately; TxD=1 next clock; buffer contents need not be cleared.

Configuration
REQ-027 Macro LA_HEADER_EN: when defined, each transmission begins with header byte 0xA5 sent (full 8N1 frame) before sample 0, total DEPTH+1 frames; when undefined, exactly DEPTH frames, no header.

Verification
REQ-028 Reset 5 clocks, dataIn=000 -> TxD=1, state_debug=0 during reset, state_debug=1 within 2 clocks after release.
REQ-029 Armed with reference 000, dataIn steps 001,010,011,100,101,110 every 1.5 clocks -> trigger on 001; bytes 0x01 then fifteen 0x06 (DEPTH=16), each frame 160 clocks.
REQ-030 Check TxD frame for 0x06: low 16 clocks, bits 0,1,1,0,0,0,0,0 at 16 clocks each, high 16 clocks; dataOut_debug=0x06 during frame.
REQ-031 dataIn toggled during TX_DATA -> no retrigger, byte sequence unchanged; after DONE, state returns 0 then 1.
REQ-032 rst pulsed one clock during TX_DATA -> TxD=1 and state_debug=0 next clock; new trigger afterwards captures normally.
REQ-033 With LA_HEADER_EN defined -> first frame 0xA5, then sample bytes; pll_output_debug period 2 clocks, clk_div16_debug period 16 clocks throughout.
